ota_cmp_sequencer: RTL and testbench

Sequencer and round-robin arbiter that shares the single on-chip OTA comparator among several requesting input channels. It selects the analog input pair through the mux select, enables the comparator, waits a programmable settle time, samples the synchronized comparator output, and returns a one-bit decision tagged with its channel over a valid/ready handshake. It sits between the digital request logic and the comparator macro's enable/select/output pins.

---
 rtl/ota_cmp_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_ota_cmp_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ota_cmp_sequencer.sv
// ota_cmp_sequencer
//
// Shares the single OTA comparator among NCH requesting channels. A
// round-robin arbiter picks a channel in IDLE, the analog mux is pointed at
// it, the comparator is enabled for a programmable settle time, the
// synchronized comparator output is sampled, and the decision is returned
// with its channel tag over a valid/ready handshake.
//
// Optional feature macro: OTA_CMP_MAJORITY_EN
//   defined     -> SAMPLE lasts 3 cycles, decision is the majority of 3 samples
//   not defined -> SAMPLE lasts 1 cycle, decision is the single sample
//
// Ports:
//   i_clk            clock
//   i_rst            synchronous active-high reset
//   i_req            level request per channel
//   i_settle_cycles  settle count S, latched at grant (SETTLE lasts S+1 cycles)
//   i_cmp_in         raw comparator output, asynchronous to i_clk
//   o_mux_sel        analog input mux select
//   o_cmp_en         comparator enable
//   o_busy           high in any state except IDLE
//   o_res_valid      result available
//   i_res_ready      consumer accepts the result
//   o_res_ch         channel of the current result
//   o_res_bit        decision, 1 means Vip > Vin
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request, arbitration happens here
// SETTLE | mux selected, comparator enabled, counting down settle time
// SAMPLE | capturing the synchronized comparator output
// HOLD   | result presented, waiting for the consumer handshake

module ota_cmp_sequencer #(
    parameter int NCH      = 4,
    parameter int CHW      = $clog2(NCH),
    parameter int SETTLE_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NCH-1:0]      i_req,
    input  logic [SETTLE_W-1:0] i_settle_cycles,
    input  logic                i_cmp_in,
    output logic [CHW-1:0]      o_mux_sel,
    output logic                o_cmp_en,
    output logic                o_busy,
    output logic                o_res_valid,
    input  logic                i_res_ready,
    output logic [CHW-1:0]      o_res_ch,
    output logic                o_res_bit
);

    // Encoding chosen so that bit 0 is exactly "comparator enabled" and every
    // transition along the conversion path flips a single bit; the comparator
    // enable therefore comes straight off a flop without decode glitches.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_SAMPLE = 2'b11,
        ST_HOLD   = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [CHW-1:0]        r_ptr;
    logic [CHW-1:0]        r_mux_sel;
    logic [SETTLE_W-1:0]   r_cnt;
    logic [CHW-1:0]        r_res_ch;
    logic                  r_res_bit;
    logic                  r_sync1;
    logic                  r_sync2;

    logic                  w_cmp_sync;
    logic                  w_grant_vld;
    logic [CHW-1:0]        w_grant;
    logic [CHW-1:0]        w_idx;
    logic [CHW-1:0]        w_ptr_nxt;
    logic                  w_sample_done;
    logic                  w_decision;
    logic                  w_handshake;

    assign w_cmp_sync  = r_sync2;
    assign w_handshake = (r_state == ST_HOLD) && i_res_ready;

    // Round-robin search: scan offsets from high to low so the lowest offset
    // from r_ptr (the first set bit at or after the pointer) wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            w_idx = CHW'((int'(r_ptr) + i) % NCH);
            if (i_req[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (w_grant == CHW'(NCH - 1)) ? '0 : w_grant + CHW'(1);

`ifdef OTA_CMP_MAJORITY_EN
    logic [1:0] r_samp;
    logic [1:0] r_samp_cnt;

    assign w_sample_done = (r_samp_cnt == 2'd2);
    // Third sample is taken live on the final SAMPLE edge.
    assign w_decision    = (r_samp[1] & r_samp[0]) |
                           (r_samp[1] & w_cmp_sync) |
                           (r_samp[0] & w_cmp_sync);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_samp     <= '0;
            r_samp_cnt <= '0;
        end else if (r_state == ST_SAMPLE) begin
            r_samp     <= {r_samp[0], w_cmp_sync};
            r_samp_cnt <= w_sample_done ? 2'd0 : r_samp_cnt + 2'd1;
        end
    end
`else
    assign w_sample_done = 1'b1;
    assign w_decision    = w_cmp_sync;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant_vld) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_cnt == '0) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: if (w_sample_done) w_state_nxt = ST_HOLD;
            ST_HOLD:   if (w_handshake) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_cmp_en    = r_state[0];
        o_busy      = (r_state != ST_IDLE);
        o_res_valid = (r_state == ST_HOLD);
        o_mux_sel   = r_mux_sel;
        o_res_ch    = r_res_ch;
        o_res_bit   = r_res_bit;
    end

    // Datapath: synchronizer, arbitration pointer, settle timer, result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_ptr     <= '0;
            r_mux_sel <= '0;
            r_cnt     <= '0;
            r_res_ch  <= '0;
            r_res_bit <= 1'b0;
        end else begin
            r_sync1 <= i_cmp_in;
            r_sync2 <= r_sync1;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_mux_sel <= w_grant;
                        r_cnt     <= i_settle_cycles;
                        r_ptr     <= w_ptr_nxt;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - SETTLE_W'(1);
                end
                ST_SAMPLE: begin
                    if (w_sample_done) begin
                        r_res_bit <= w_decision;
                        r_res_ch  <= r_mux_sel;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ota_cmp_sequencer.sv
// Testbench for ota_cmp_sequencer. Directed scenarios followed by randomized
// conversions, each checked against a transaction-level reference model.
module tb_ota_cmp_sequencer;

    localparam int NCH      = 4;
    localparam int CHW      = 2;
    localparam int SETTLE_W = 4;
`ifdef OTA_CMP_MAJORITY_EN
    localparam int NSAMP = 3;
`else
    localparam int NSAMP = 1;
`endif

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic [NCH-1:0]      i_req = '0;
    logic [SETTLE_W-1:0] i_settle_cycles = '0;
    logic                i_cmp_in = 1'b0;
    logic [CHW-1:0]      o_mux_sel;
    logic                o_cmp_en;
    logic                o_busy;
    logic                o_res_valid;
    logic                i_res_ready = 1'b0;
    logic [CHW-1:0]      o_res_ch;
    logic                o_res_bit;

    int n_vec = 0;
    int n_err = 0;
    int m_ptr = 0;

    ota_cmp_sequencer #(.NCH(NCH), .SETTLE_W(SETTLE_W)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req           (i_req),
        .i_settle_cycles (i_settle_cycles),
        .i_cmp_in        (i_cmp_in),
        .o_mux_sel       (o_mux_sel),
        .o_cmp_en        (o_cmp_en),
        .o_busy          (o_busy),
        .o_res_valid     (o_res_valid),
        .i_res_ready     (i_res_ready),
        .o_res_ch        (o_res_ch),
        .o_res_bit       (o_res_bit)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requesting channel at or after p, wrapping; -1 when none.
    function automatic int arb_pick(input logic [NCH-1:0] r, input int p);
        for (int i = 0; i < NCH; i++) begin
            if (r[(p + i) % NCH]) return (p + i) % NCH;
        end
        return -1;
    endfunction

    // Starts in an IDLE cycle (#1 after an edge) and ends in the IDLE cycle
    // following the handshake. v[c] is the comparator input during cycle c
    // (cycle c follows edge c-1, grant is edge 0); the 2-flop synchronizer
    // makes the SAMPLE cycles see v[S], v[S+1], v[S+2].
    task automatic do_conv(input logic [NCH-1:0] reqv, input int s, input int hold,
                           input bit use_pat, input logic [2:0] pat, input bit drop_req);
        int             g;
        int             v[32];
        int             last;
        logic [CHW-1:0] gg;
        logic           eb;
        g = arb_pick(reqv, m_ptr);
        m_ptr = (g + 1) % NCH;
        gg = g[CHW-1:0];
        for (int c = 0; c < 32; c++) v[c] = int'($urandom_range(0, 1));
        if (use_pat) for (int k = 0; k < 3; k++) v[s + k] = int'(pat[k]);
        if (NSAMP == 3) eb = ((v[s] + v[s + 1] + v[s + 2]) >= 2);
        else            eb = (v[s] != 0);
        last = s + 2 + NSAMP;

        chk("idle_before_grant", {o_busy, o_res_valid}, 2'b00);
        i_req           = reqv;
        i_settle_cycles = SETTLE_W'(s);
        i_cmp_in        = 1'(v[0]);
        i_res_ready     = 1'($urandom_range(0, 1));

        for (int c = 1; c < last; c++) begin
            @(posedge i_clk); #1;
            chk("converting", {o_busy, o_cmp_en, o_res_valid, o_mux_sel},
                {1'b1, 1'b1, 1'b0, gg});
            i_cmp_in        = 1'(v[c]);
            i_req           = drop_req ? '0 : NCH'($urandom);
            i_settle_cycles = SETTLE_W'($urandom);
            i_res_ready     = 1'($urandom_range(0, 1));
        end
        i_res_ready = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            @(posedge i_clk); #1;
            chk("hold_result", {o_busy, o_cmp_en, o_res_valid, o_mux_sel, o_res_ch, o_res_bit},
                {1'b1, 1'b0, 1'b1, gg, gg, eb});
            i_res_ready = (h == hold);
        end
        @(posedge i_clk); #1;
        chk("idle_after_handshake", {o_busy, o_cmp_en, o_res_valid, o_mux_sel},
            {1'b0, 1'b0, 1'b0, gg});
        i_res_ready = 1'b0;
    endtask

    initial begin
        logic [NCH-1:0] rq;
        int             g;

        // Reset values
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_values", {o_busy, o_cmp_en, o_res_valid, o_mux_sel, o_res_ch, o_res_bit}, '0);
        i_rst = 1'b0;

        // No request: stays idle
        repeat (4) begin
            @(posedge i_clk); #1;
            chk("idle_no_req", {o_busy, o_cmp_en, o_res_valid}, 3'b000);
        end

        // Round-robin with all requests held high: expected order 0,1,2,3,0
        for (int k = 0; k < 5; k++) do_conv(4'b1111, 1, 0, 1'b0, 3'b000, 1'b0);

        // Single request on channel 2, S=3, comparator high
        do_conv(4'b0100, 3, 0, 1'b1, 3'b111, 1'b0);

        // Backpressure for 10 cycles
        do_conv(4'b1011, 2, 10, 1'b0, 3'b000, 1'b0);

        // Sample patterns 1,0,1 and 0,1,0
        do_conv(4'b0010, 2, 1, 1'b1, 3'b101, 1'b0);
        do_conv(4'b1000, 4, 0, 1'b1, 3'b010, 1'b0);

        // S=0 with request dropped immediately after the grant
        do_conv(4'b0001, 0, 0, 1'b1, 3'b111, 1'b1);
        do_conv(4'b0100, 0, 0, 1'b1, 3'b000, 1'b1);

        // Reset mid-SETTLE: grant channel 1 (pointer would move to 2), S=5
        rq = 4'b0010;
        g = arb_pick(rq, m_ptr);
        i_req = rq;
        i_settle_cycles = 4'd5;
        @(posedge i_clk); #1;
        chk("pre_reset_busy", {o_busy, o_cmp_en, o_mux_sel}, {1'b1, 1'b1, 2'(g)});
        i_req = '0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk("mid_settle_reset", {o_busy, o_cmp_en, o_res_valid, o_mux_sel, o_res_ch, o_res_bit}, '0);
        i_rst = 1'b0;
        m_ptr = 0;
        repeat (10) begin
            @(posedge i_clk); #1;
            chk("post_reset_quiet", {o_busy, o_res_valid}, 2'b00);
        end
        do_conv(4'b1111, 0, 0, 1'b0, 3'b000, 1'b0);

        // Randomized conversions
        for (int k = 0; k < 40; k++) begin
            do_conv(NCH'($urandom_range(1, (1 << NCH) - 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), 1'b0, 3'b000, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
